// File: rtl/abus_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// abus_cmd_sequencer
//
// Purpose:
//   Queues read/write commands in a small FIFO and executes them on the
//   abus_master request interface strictly one at a time, in push order.
//   Each executed command produces exactly one response that is held until
//   the consumer accepts it.
//
// Ports:
//   abus_clk, abus_rst      clock and synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_write selects write/read,
//   cmd_addr, cmd_wdata     command address and write data
//   rsp_valid/rsp_ready     response handshake
//   rsp_write, rsp_err,     response kind, error flag and read data
//   rsp_rdata               (read data is 0 for writes and errored reads)
//   m_write/m_read          level requests towards abus_master
//   m_address, m_wdata      request address and write data
//   m_done, m_new_rdata,    completion strobes and read data from
//   m_err, m_rdata          abus_master
//   level                   commands queued, excluding the one in flight
//   busy                    a command is in flight/responding or queued
// ---------------------------------------------------------------------------
module abus_cmd_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                    abus_clk,
    input  logic                    abus_rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic                    rsp_err,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,

    output logic                    m_write,
    output logic                    m_read,
    output logic [ADDR_WIDTH-1:0]   m_address,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic                    m_done,
    input  logic                    m_new_rdata,
    input  logic                    m_err,
    input  logic [DATA_WIDTH-1:0]   m_rdata,

    output logic [$clog2(DEPTH):0]  level,
    output logic                    busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    state_t        state;
    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          complete;

    // cmd_ready depends only on the registered level, so there is no
    // combinational path from cmd_valid back to cmd_ready.
    assign cmd_ready = (level != FULL_LEVEL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (level != '0);
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || (level != '0);

    // Only the strobe matching the request kind completes it; m_err
    // completes either kind.
    assign complete  = (state == ISSUE) &&
                       (m_write ? (m_done || m_err) : (m_new_rdata || m_err));

    // NOTE: the storage array has no reset; emptiness is tracked purely by
    // level and the pointers, so stale entries are never observed.
    always_ff @(posedge abus_clk) begin
        if (!abus_rst && push) begin
            mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
        end
    end

    // NOTE: all state below uses non-blocking assignments so every branch
    // reads the pre-edge values (e.g. rsp_write captures the old m_write).
    always_ff @(posedge abus_clk) begin
        if (abus_rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            m_write   <= 1'b0;
            m_read    <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        m_address <= head.addr;
                        m_wdata   <= head.wdata;
                        m_write   <= head.write;
                        m_read    <= !head.write;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (complete) begin
                        m_write   <= 1'b0;
                        m_read    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= m_write;
                        rsp_err   <= m_err;
                        rsp_rdata <= (!m_write && !m_err) ? m_rdata : '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_abus_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_abus_cmd_sequencer
//
// Self-checking bench for abus_cmd_sequencer (default parameters).
// Directed vector table for single transactions, hand-written sequences for
// fill/order, stray completions and reset mid-operation, then a randomized
// phase checked against a transaction-level reference model (command queue
// plus expected-response queue).
// ---------------------------------------------------------------------------
module tb_abus_cmd_sequencer;

    logic        abus_clk = 1'b0;
    logic        abus_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic        rsp_err;
    logic [15:0] rsp_rdata;
    logic        m_write;
    logic        m_read;
    logic [15:0] m_address;
    logic [15:0] m_wdata;
    logic        m_done;
    logic        m_new_rdata;
    logic        m_err;
    logic [15:0] m_rdata;
    logic [2:0]  level;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 abus_clk = ~abus_clk;

    abus_cmd_sequencer #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .DEPTH      (4)
    ) dut (
        .abus_clk    (abus_clk),
        .abus_rst    (abus_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .m_write     (m_write),
        .m_read      (m_read),
        .m_address   (m_address),
        .m_wdata     (m_wdata),
        .m_done      (m_done),
        .m_new_rdata (m_new_rdata),
        .m_err       (m_err),
        .m_rdata     (m_rdata),
        .level       (level),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: inputs were driven at a falling edge, the DUT samples them
    // on the rising edge, and outputs are looked at on the next falling edge.
    task automatic step();
        @(posedge abus_clk);
        @(negedge abus_clk);
    endtask

    task automatic clear_inputs();
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        rsp_ready   = 1'b0;
        m_done      = 1'b0;
        m_new_rdata = 1'b0;
        m_err       = 1'b0;
        m_rdata     = '0;
    endtask

    task automatic do_reset(input string tag);
        abus_rst = 1'b1;
        step();
        step();
        abus_rst = 1'b0;
        check({tag, "_m_write"},   m_write,   0);
        check({tag, "_m_read"},    m_read,    0);
        check({tag, "_m_address"}, m_address, 0);
        check({tag, "_m_wdata"},   m_wdata,   0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_write"}, rsp_write, 0);
        check({tag, "_rsp_err"},   rsp_err,   0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_level"},     level,     0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    // Wait (bounded) for a request to be raised.
    task automatic wait_req(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (m_write || m_read) break;
            step();
        end
        check({tag, "_req_seen"}, m_write || m_read, 1);
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        done;
        logic        new_rdata;
        logic        err;
        logic [15:0] rdata;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    // ------------------------------------------------------- reference model
    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
    } cmd_s;

    typedef struct {
        logic        write;
        logic        err;
        logic [15:0] rdata;
    } rsp_s;

    cmd_s cmd_q[$];
    rsp_s rsp_q[$];

    initial begin
        vec_t  v;
        cmd_s  cur;
        rsp_s  r;
        logic  req;
        logic  prev_req;
        logic  inflight;
        logic  expect_rsp;
        logic  rsp_pending;
        logic  saw_activity;

        //                write addr     wdata    done nrd  err  rdata    e_err e_rdata
        vecs[0] = '{1'b1, 16'h0012, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 16'h0040, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h1234};
        vecs[2] = '{1'b0, 16'h0041, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 16'h0000};
        vecs[3] = '{1'b1, 16'h0042, 16'h00AA, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vecs[4] = '{1'b1, 16'h0043, 16'h00BB, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vecs[5] = '{1'b0, 16'h0044, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h7777, 1'b1, 16'h0000};

        clear_inputs();
        abus_rst = 1'b1;
        @(negedge abus_clk);
        do_reset("por");

        // ------------------------------------------------ single transactions
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            cmd_write = v.write;
            cmd_addr  = v.addr;
            cmd_wdata = v.wdata;
            cmd_valid = 1'b1;
            check("vec_cmd_ready", cmd_ready, 1);
            step();
            cmd_valid = 1'b0;
            check("vec_level_after_push", level, 1);
            check("vec_no_req_yet", m_write || m_read, 0);
            step();
            check("vec_m_write", m_write, v.write);
            check("vec_m_read", m_read, !v.write);
            check("vec_m_address", m_address, v.addr);
            if (v.write) check("vec_m_wdata", m_wdata, v.wdata);
            check("vec_level_issued", level, 0);
            check("vec_busy_issue", busy, 1);
            m_done      = v.done;
            m_new_rdata = v.new_rdata;
            m_err       = v.err;
            m_rdata     = v.rdata;
            step();
            m_done = 1'b0; m_new_rdata = 1'b0; m_err = 1'b0; m_rdata = 16'hDEAD;
            check("vec_req_dropped", m_write || m_read, 0);
            check("vec_rsp_valid", rsp_valid, 1);
            check("vec_rsp_write", rsp_write, v.write);
            check("vec_rsp_err", rsp_err, v.exp_err);
            check("vec_rsp_rdata", rsp_rdata, v.exp_rdata);
            step();
            check("vec_rsp_hold_valid", rsp_valid, 1);
            check("vec_rsp_hold_rdata", rsp_rdata, v.exp_rdata);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            check("vec_rsp_consumed", rsp_valid, 0);
            check("vec_busy_idle", busy, 0);
        end

        // --------------------------------------------------- stray completions
        m_done = 1'b1; m_new_rdata = 1'b1; m_err = 1'b1;
        step();
        m_done = 1'b0; m_new_rdata = 1'b0; m_err = 1'b0;
        step();
        check("stray_idle_rsp", rsp_valid, 0);
        check("stray_idle_busy", busy, 0);
        cmd_write = 1'b1; cmd_addr = 16'h0077; cmd_wdata = 16'h0101; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        check("stray_write_issued", m_write, 1);
        m_new_rdata = 1'b1;
        step();
        step();
        m_new_rdata = 1'b0;
        check("stray_write_held", m_write, 1);
        check("stray_write_no_rsp", rsp_valid, 0);
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        check("stray_write_done_req", m_write, 0);
        check("stray_write_done_rsp", rsp_valid, 1);
        check("stray_write_rsp_write", rsp_write, 1);
        check("stray_write_rsp_err", rsp_err, 0);
        m_err = 1'b1;
        step();
        m_err = 1'b0;
        check("stray_resp_err_ignored", rsp_err, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("stray_done_idle", busy, 0);

        // ------------------------------------------------------ fill and order
        for (int i = 0; i < 5; i++) begin
            cmd_write = (i % 2 == 0);
            cmd_addr  = 16'h0100 + 16'(i);
            cmd_wdata = 16'hA000 + 16'(i);
            cmd_valid = 1'b1;
            check("fill_cmd_ready", cmd_ready, 1);
            step();
        end
        cmd_valid = 1'b0;
        check("fill_level_full", level, 4);
        check("fill_cmd_ready_low", cmd_ready, 0);
        check("fill_in_flight", m_write || m_read, 1);
        step();
        check("fill_still_full", cmd_ready, 0);
        for (int i = 0; i < 5; i++) begin
            wait_req("fill");
            check("fill_order_addr", m_address, 16'h0100 + 16'(i));
            check("fill_order_kind", m_write, (i % 2 == 0));
            if (i % 2 == 0) m_done = 1'b1;
            else begin m_new_rdata = 1'b1; m_rdata = 16'hC000 + 16'(i); end
            step();
            m_done = 1'b0; m_new_rdata = 1'b0;
            check("fill_rsp_valid", rsp_valid, 1);
            check("fill_rsp_write", rsp_write, (i % 2 == 0));
            check("fill_rsp_rdata", rsp_rdata, (i % 2 == 0) ? 16'h0000 : 16'hC000 + 16'(i));
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
        check("fill_drained", busy, 0);

        // --------------------------------------------- reset mid-transaction
        for (int i = 0; i < 3; i++) begin
            cmd_write = 1'b0;
            cmd_addr  = 16'h0200 + 16'(i);
            cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        check("rst_mid_level", level, 2);
        check("rst_mid_read", m_read, 1);
        abus_rst = 1'b1; cmd_valid = 1'b1; m_new_rdata = 1'b1; m_done = 1'b1;
        rsp_ready = 1'b1;
        step();
        abus_rst = 1'b0;
        clear_inputs();
        check("rst_mid_m_read", m_read, 0);
        check("rst_mid_m_write", m_write, 0);
        check("rst_mid_level0", level, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        saw_activity = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid || m_read || m_write || busy) saw_activity = 1'b1;
        end
        check("rst_mid_dropped_quiet", saw_activity, 0);

        // ----------------------------------------------------- random phase
        do_reset("rnd_rst");
        prev_req   = 1'b0;
        inflight   = 1'b0;
        expect_rsp = 1'b0;
        cur        = '{default: '0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req = m_write || m_read;
            if (req && !prev_req) begin
                check("rnd_issue_pending", cmd_q.size() != 0, 1);
                if (cmd_q.size() != 0) cur = cmd_q.pop_front();
                inflight = 1'b1;
            end
            if (req) begin
                check("rnd_req_kind", m_write, cur.write);
                check("rnd_req_addr", m_address, cur.addr);
                if (cur.write) check("rnd_req_wdata", m_wdata, cur.wdata);
            end
            check("rnd_exclusive", m_write && m_read, 0);
            if (expect_rsp) begin
                check("rnd_req_dropped", req, 0);
                check("rnd_rsp_arrived", rsp_valid, 1);
            end
            if (rsp_valid) begin
                check("rnd_rsp_expected", rsp_q.size() != 0, 1);
                if (rsp_q.size() != 0) begin
                    check("rnd_rsp_write", rsp_write, rsp_q[0].write);
                    check("rnd_rsp_err", rsp_err, rsp_q[0].err);
                    check("rnd_rsp_rdata", rsp_rdata, rsp_q[0].rdata);
                end
            end
            check("rnd_level", level, cmd_q.size());
            check("rnd_cmd_ready", cmd_ready, cmd_q.size() != 4);
            check("rnd_busy", busy, (cmd_q.size() != 0) || inflight);
            expect_rsp  = 1'b0;
            rsp_pending = (rsp_q.size() != 0);

            cmd_valid = $urandom_range(0, 1);
            cmd_write = $urandom_range(0, 1);
            cmd_addr  = 16'($urandom);
            cmd_wdata = 16'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            m_rdata   = 16'($urandom);
            if (req && $urandom_range(0, 2) == 0) begin
                m_err = ($urandom_range(0, 3) == 0);
                if (cur.write) begin
                    m_done      = !m_err || ($urandom_range(0, 1) == 1);
                    m_new_rdata = $urandom_range(0, 1);
                end else begin
                    m_new_rdata = !m_err || ($urandom_range(0, 1) == 1);
                    m_done      = $urandom_range(0, 1);
                end
                r.write = cur.write;
                r.err   = m_err;
                r.rdata = (!cur.write && !m_err) ? m_rdata : 16'h0000;
                rsp_q.push_back(r);
                expect_rsp = 1'b1;
            end else if (req) begin
                m_err       = 1'b0;
                m_done      = cur.write ? 1'b0 : 1'($urandom_range(0, 1));
                m_new_rdata = cur.write ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                m_err       = $urandom_range(0, 1);
                m_done      = $urandom_range(0, 1);
                m_new_rdata = $urandom_range(0, 1);
            end

            if (cmd_valid && cmd_q.size() != 4)
                cmd_q.push_back('{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata});
            if (rsp_pending && rsp_ready) begin
                void'(rsp_q.pop_front());
                inflight = 1'b0;
            end
            prev_req = req;
            step();
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/abus_cmd_sequencer.md
ABUS_CMD_SEQUENCER -- requirements
Module: abus_cmd_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_WIDTH, default 16, bus address width.
- DATA_WIDTH, default 16, bus data width.
- DEPTH, default 4, command FIFO entries; power of two, at least 2.

REQ-002 The block SHALL have these ports:
- abus_clk  in  1  single clock; all state updates on its rising edge.
- abus_rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command slot available.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_err  out  1  transaction failed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errored reads.
- m_write  out  1  level write request to abus_master.
- m_read  out  1  level read request to abus_master.
- m_address  out  ADDR_WIDTH  request address.
- m_wdata  out  DATA_WIDTH  request write data.
- m_done  in  1  write completed.
- m_new_rdata  in  1  read data valid.
- m_err  in  1  transaction error.
- m_rdata  in  DATA_WIDTH  read data.
- level  out  clog2(DEPTH)+1  commands queued, excluding the one in flight.
- busy  out  1  high when the FSM is not IDLE or level != 0.

Function
REQ-003 A command SHALL be pushed on an edge where cmd_valid && cmd_ready; cmd_ready = (level != DEPTH), driven combinationally from registered level only.
REQ-004 A simultaneous push and pop SHALL leave level unchanged; a push while full SHALL be impossible by construction; FIFO pointers SHALL wrap modulo DEPTH.
REQ-005 The FSM SHALL have exactly three states: IDLE, ISSUE, RESP.
REQ-006 In IDLE with level != 0, the next edge SHALL pop the FIFO head, register m_address/m_wdata, assert exactly one of m_write/m_read per cmd_write, and enter ISSUE.
REQ-007 Latency: a command pushed at edge N into an empty, idle block SHALL have its m_write/m_read high after edge N+1.
REQ-008 In ISSUE, m_write/m_read, m_address and m_wdata SHALL be held stable until completion.
REQ-009 Completion conditions in ISSUE:
- Write completes when m_done || m_err is sampled high.
- Read completes when m_new_rdata || m_err is sampled high.
REQ-010 On the completion edge, the block SHALL:
- deassert m_write/m_read;
- capture rsp_write;
- set rsp_err = m_err (m_err has priority when sampled together with m_done or m_new_rdata);
- set rsp_rdata = m_rdata for a successful read, else 0;
- assert rsp_valid and enter RESP.
REQ-011 In RESP, rsp_* SHALL hold stable until an edge with rsp_ready high; that edge SHALL clear rsp_valid and return to IDLE; the next pop occurs no earlier than the following edge.
REQ-012 m_done, m_new_rdata and m_err SHALL be ignored in IDLE and RESP; m_new_rdata SHALL not complete a write, and m_done SHALL not complete a read.
REQ-013 Commands SHALL be executed and responded to strictly in push order, one in flight at a time.
REQ-014 m_write and m_read SHALL never be high in the same cycle.

Reset
REQ-015 An edge with abus_rst high SHALL force the following, regardless of state, including mid-transaction:
- FSM = IDLE, FIFO emptied, level = 0;
- m_write = m_read = 0, m_address = 0, m_wdata = 0;
- rsp_valid = rsp_write = rsp_err = 0, rsp_rdata = 0;
- busy = 0, cmd_ready = 1.
REQ-016 Pushes, completions and rsp_ready presented during a reset cycle SHALL be discarded.

Verification
REQ-017 Single write: push write addr 0x0012 data 0xBEEF at edge N. Required: m_write = 1, m_address = 0x0012, m_wdata = 0xBEEF after edge N+1; m_done pulsed -> rsp_valid = 1, rsp_write = 1, rsp_err = 0, rsp_rdata = 0.
REQ-018 Single read: push read addr 0x0040; m_new_rdata with m_rdata = 0x1234. Required: m_read drops on the same edge; rsp_rdata = 0x1234, rsp_err = 0.
REQ-019 Fill and order: with rsp_ready = 0, push 5 commands (DEPTH = 4). Required:
- cmd_ready = 0 once level = 4, with one command in flight or in RESP.
- After rsp_ready = 1, all 5 responses return in push order.
REQ-020 Error priority: read with m_err and m_new_rdata high together. Required: rsp_err = 1, rsp_rdata = 0. Write with m_err alone: rsp_err = 1.
REQ-021 Stray completions: pulse m_done and m_new_rdata in IDLE, then issue a write and pulse m_new_rdata. Required: no response; the write completes only on m_done.
REQ-022 Reset mid-operation: assert abus_rst while in ISSUE with level = 2. Required: after that edge, m_read = m_write = 0, level = 0, rsp_valid = 0, busy = 0; no response is ever produced for the dropped commands.
